// File: rtl/cam_frame_capture.sv
// cam_frame_capture
//
// Purpose:
//   Captures exactly one complete camera frame in the pixel-clock domain and
//   presents it to the frame dump buffer as a registered byte stream with a
//   linear write address. An arm request waits for the next full frame, so
//   a request that arrives mid-frame never yields a partial frame. Bytes
//   beyond MAX_BYTES are dropped, and a sticky overflow flag reports them.
//
// Parameters:
//   ADDR_W     width of write_addr
//   MAX_BYTES  bytes accepted per frame (must be <= 2**ADDR_W)
//
// Ports:
//   cam_clk          camera pixel clock (PCLK), the only clock
//   cam_reset        synchronous, active-high reset
//   arm              single-cycle request to capture the next complete frame
//   vsync            camera VSYNC, high during vertical blanking
//   href             camera HREF, high while line bytes are valid
//   cam_d[7:0]       camera data bus
//   busy             high from the accepted arm until frame_end
//   frame_start      one-cycle pulse on the first cycle of the captured frame
//   frame_end        one-cycle pulse when the frame is complete
//   write_en         write strobe to the dump buffer
//   write_data[7:0]  byte to write
//   write_addr       linear byte address of write_data
//   overflow         sticky: frame exceeded MAX_BYTES, cleared by next arm
//
// Optional feature (macro CAM_CAPTURE_STATS_EN):
//   line_count[11:0]       HREF rising edges seen in the captured frame
//   last_line_bytes[11:0]  bytes in the most recent line
//   Both counters clear at frame_start and freeze at frame_end.
//   Without the macro these ports and counters do not exist.

module cam_frame_capture #(
  parameter int ADDR_W    = 16,
  parameter int MAX_BYTES = 38400
) (
  input  logic              cam_clk,
  input  logic              cam_reset,
  input  logic              arm,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        cam_d,
  output logic              busy,
  output logic              frame_start,
  output logic              frame_end,
  output logic              write_en,
  output logic [7:0]        write_data,
  output logic [ADDR_W-1:0] write_addr,
  output logic              overflow
`ifdef CAM_CAPTURE_STATS_EN
  ,
  output logic [11:0]       line_count,
  output logic [11:0]       last_line_bytes
`endif
);

  typedef enum logic [1:0] {IDLE, SYNC, WAIT, CAPT} state_t;

  // One extra bit lets the counter hold MAX_BYTES itself when
  // MAX_BYTES == 2**ADDR_W, so write_addr never wraps.
  localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W+1)'(MAX_BYTES);

  state_t            state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              busy_q, busy_d;
  logic              frame_start_q, frame_start_d;
  logic              frame_end_q, frame_end_d;
  logic              write_en_q, write_en_d;
  logic [7:0]        write_data_q, write_data_d;
  logic [ADDR_W-1:0] write_addr_q, write_addr_d;
  logic              overflow_q, overflow_d;

  // Input stage: one register on every camera pin, plus the previous
  // registered vsync for edge detection.
  logic       vsync_r_q, href_r_q, vsync_prev_q;
  logic [7:0] data_r_q;

  logic vs_rise, vs_fall, byte_valid;

  assign vs_rise    = vsync_r_q & ~vsync_prev_q;
  assign vs_fall    = ~vsync_r_q & vsync_prev_q;
  assign byte_valid = href_r_q & ~vsync_r_q;

`ifdef CAM_CAPTURE_STATS_EN
  logic        href_prev_q;
  logic [11:0] line_count_q, line_count_d;
  logic [11:0] line_bytes_q, line_bytes_d;
`endif

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    busy_d        = busy_q;
    frame_start_d = 1'b0;
    frame_end_d   = 1'b0;
    write_en_d    = 1'b0;
    write_data_d  = 8'd0;
    write_addr_d  = '0;
    overflow_d    = overflow_q;
`ifdef CAM_CAPTURE_STATS_EN
    line_count_d  = line_count_q;
    line_bytes_d  = line_bytes_q;
`endif

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (arm) begin
          state_d    = SYNC;
          busy_d     = 1'b1;
          overflow_d = 1'b0;
          count_d    = '0;
        end
      end

      // Waiting for the start of vertical blanking ensures that the frame
      // captured next is seen from its very first line.
      SYNC: begin
        if (vs_rise) state_d = WAIT;
      end

      WAIT: begin
        if (vs_fall) begin
          state_d       = CAPT;
          frame_start_d = 1'b1;
`ifdef CAM_CAPTURE_STATS_EN
          line_count_d  = '0;
          line_bytes_d  = '0;
`endif
        end
      end

      // The vsync rise takes priority, so a byte that coincides with the
      // end of the frame is dropped.
      CAPT: begin
        if (vs_rise) begin
          state_d     = IDLE;
          frame_end_d = 1'b1;
          busy_d      = 1'b0;
        end else if (byte_valid) begin
          if (count_q < MAX_CNT) begin
            write_en_d   = 1'b1;
            write_data_d = data_r_q;
            write_addr_d = count_q[ADDR_W-1:0];
            count_d      = count_q + 1'b1;
          end else begin
            overflow_d = 1'b1;
          end
`ifdef CAM_CAPTURE_STATS_EN
          if (!href_prev_q) begin
            line_count_d = line_count_q + 12'd1;
            line_bytes_d = 12'd1;
          end else begin
            line_bytes_d = line_bytes_q + 12'd1;
          end
`endif
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge cam_clk) begin
    if (cam_reset) begin
      state_q       <= IDLE;
      count_q       <= '0;
      busy_q        <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      write_en_q    <= 1'b0;
      write_data_q  <= 8'd0;
      write_addr_q  <= '0;
      overflow_q    <= 1'b0;
      vsync_r_q     <= 1'b0;
      href_r_q      <= 1'b0;
      vsync_prev_q  <= 1'b0;
      data_r_q      <= 8'd0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      busy_q        <= busy_d;
      frame_start_q <= frame_start_d;
      frame_end_q   <= frame_end_d;
      write_en_q    <= write_en_d;
      write_data_q  <= write_data_d;
      write_addr_q  <= write_addr_d;
      overflow_q    <= overflow_d;
      vsync_r_q     <= vsync;
      href_r_q      <= href;
      vsync_prev_q  <= vsync_r_q;
      data_r_q      <= cam_d;
    end
  end

`ifdef CAM_CAPTURE_STATS_EN
  always_ff @(posedge cam_clk) begin
    if (cam_reset) begin
      href_prev_q  <= 1'b0;
      line_count_q <= '0;
      line_bytes_q <= '0;
    end else begin
      href_prev_q  <= href_r_q;
      line_count_q <= line_count_d;
      line_bytes_q <= line_bytes_d;
    end
  end

  assign line_count      = line_count_q;
  assign last_line_bytes = line_bytes_q;
`endif

  assign busy        = busy_q;
  assign frame_start = frame_start_q;
  assign frame_end   = frame_end_q;
  assign write_en    = write_en_q;
  assign write_data  = write_data_q;
  assign write_addr  = write_addr_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_cam_frame_capture.sv
// tb_cam_frame_capture
//
// Bench for cam_frame_capture. The DUT is built with a reduced frame size
// (10 lines x 20 bytes, MAX_BYTES = 200, ADDR_W = 8) so that several whole
// frames fit in a short run while still reaching the byte-limit boundary.
// Every byte expected to be written is queued when it is driven, and it is
// popped and compared when write_en appears.
// Stats outputs are connected and checked when CAM_CAPTURE_STATS_EN is defined.

module tb_cam_frame_capture;

  localparam int ADDR_W    = 8;
  localparam int MAX_BYTES = 200;
  localparam int LINES     = 10;
  localparam int BYTES     = 20;

  logic              cam_clk = 1'b0;
  logic              cam_reset;
  logic              arm;
  logic              vsync;
  logic              href;
  logic [7:0]        cam_d;
  logic              busy;
  logic              frame_start;
  logic              frame_end;
  logic              write_en;
  logic [7:0]        write_data;
  logic [ADDR_W-1:0] write_addr;
  logic              overflow;
`ifdef CAM_CAPTURE_STATS_EN
  logic [11:0]       line_count;
  logic [11:0]       last_line_bytes;
`endif

  cam_frame_capture #(.ADDR_W(ADDR_W), .MAX_BYTES(MAX_BYTES)) dut (
    .cam_clk         (cam_clk),
    .cam_reset       (cam_reset),
    .arm             (arm),
    .vsync           (vsync),
    .href            (href),
    .cam_d           (cam_d),
    .busy            (busy),
    .frame_start     (frame_start),
    .frame_end       (frame_end),
    .write_en        (write_en),
    .write_data      (write_data),
    .write_addr      (write_addr),
    .overflow        (overflow)
`ifdef CAM_CAPTURE_STATS_EN
    ,
    .line_count      (line_count),
    .last_line_bytes (last_line_bytes)
`endif
  );

  always #5 cam_clk = ~cam_clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } wr_t;

  wr_t sb[$];

  int testsRun    = 0;
  int testsFailed = 0;
  int fsCount = 0, feCount = 0, weCount = 0;
  int fsSnap, feSnap, weSnap;
  int modelCount = 0;
  bit modelOverflow = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    if (obs !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of pin values, then step to just after the next edge.
  task automatic tick(input logic vs, input logic hr, input logic [7:0] d);
    vsync = vs;
    href  = hr;
    cam_d = d;
    @(posedge cam_clk);
    #1;
  endtask

  task automatic doArm();
    arm = 1'b1;
    tick(vsync, 1'b0, 8'd0);
    arm = 1'b0;
    modelCount    = 0;
    modelOverflow = 1'b0;
    checkOutput("busy_after_arm", 32'(busy), 32'd1);
    checkOutput("overflow_cleared", 32'(overflow), 32'd0);
  endtask

  // One frame: vsync blanking pulse (which also ends the previous frame),
  // then nLines lines of BYTES random bytes separated by short gaps.
  task automatic applyStimulus(input int nLines, input bit capture,
                               input int armLine, input int resetLine);
    bit         cap;
    logic [7:0] d;
    cap = capture;
    repeat (6) tick(1'b1, 1'b0, 8'd0);
    repeat (4) tick(1'b0, 1'b0, 8'd0);
    for (int l = 0; l < nLines; l++) begin
      if (l == resetLine) begin
        cam_reset = 1'b1;
        tick(1'b0, 1'b0, 8'd0);
        cam_reset = 1'b0;
        cap = 1'b0;
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_write_en", 32'(write_en), 32'd0);
        checkOutput("reset_write_addr", 32'(write_addr), 32'd0);
        checkOutput("reset_overflow", 32'(overflow), 32'd0);
      end
      for (int b = 0; b < BYTES; b++) begin
        d = 8'($urandom_range(0, 255));
        if (cap) begin
          if (modelCount < MAX_BYTES) begin
            sb.push_back('{addr: ADDR_W'(modelCount), data: d});
            modelCount++;
          end else begin
            modelOverflow = 1'b1;
          end
        end
        if (l == armLine && b == 0) begin
          arm = 1'b1;
          tick(1'b0, 1'b1, d);
          arm = 1'b0;
          modelCount    = 0;
          modelOverflow = 1'b0;
          checkOutput("busy_after_midframe_arm", 32'(busy), 32'd1);
        end else begin
          tick(1'b0, 1'b1, d);
        end
      end
      repeat (3) tick(1'b0, 1'b0, 8'd0);
    end
    repeat (3) tick(1'b0, 1'b0, 8'd0);
  endtask

  // Close the current frame with a vsync rise; optionally with href high
  // on that same cycle, whose byte must not be written.
  task automatic endFrame(input bit hrefOnRise);
    tick(1'b1, hrefOnRise, 8'h5A);
    repeat (5) tick(1'b1, 1'b0, 8'd0);
    repeat (4) tick(1'b0, 1'b0, 8'd0);
  endtask

  task automatic snap();
    fsSnap = fsCount;
    feSnap = feCount;
    weSnap = weCount;
  endtask

  task automatic checkFrame(input string tag, input int expFs, input int expFe, input int expWe);
    checkOutput({tag, "_frame_start_count"}, 32'(fsCount - fsSnap), 32'(expFs));
    checkOutput({tag, "_frame_end_count"}, 32'(feCount - feSnap), 32'(expFe));
    checkOutput({tag, "_write_count"}, 32'(weCount - weSnap), 32'(expWe));
    checkOutput({tag, "_scoreboard_drained"}, 32'(sb.size()), 32'd0);
    checkOutput({tag, "_overflow"}, 32'(overflow), 32'(modelOverflow));
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // Output monitor, sampling on the falling edge.
  always @(negedge cam_clk) begin
    wr_t e;
    if (frame_start) fsCount++;
    if (frame_end) begin
      feCount++;
      checkOutput("write_en_with_frame_end", 32'(write_en), 32'd0);
    end
    if (write_en) begin
      weCount++;
      if (sb.size() == 0) begin
        checkOutput("unexpected_write_en", 32'(write_en), 32'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("write_addr", 32'(write_addr), 32'(e.addr));
        checkOutput("write_data", 32'(write_data), 32'(e.data));
      end
    end
  end

  initial begin
    cam_reset = 1'b1;
    arm       = 1'b0;
    vsync     = 1'b0;
    href      = 1'b0;
    cam_d     = 8'd0;
    #1;
    repeat (3) tick(1'b0, 1'b0, 8'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_frame_start", 32'(frame_start), 32'd0);
    checkOutput("reset_frame_end", 32'(frame_end), 32'd0);
    checkOutput("reset_write_en", 32'(write_en), 32'd0);
    checkOutput("reset_write_data", 32'(write_data), 32'd0);
    checkOutput("reset_write_addr", 32'(write_addr), 32'd0);
    checkOutput("reset_overflow", 32'(overflow), 32'd0);
`ifdef CAM_CAPTURE_STATS_EN
    checkOutput("reset_line_count", 32'(line_count), 32'd0);
    checkOutput("reset_last_line_bytes", 32'(last_line_bytes), 32'd0);
`endif
    cam_reset = 1'b0;
    repeat (2) tick(1'b0, 1'b0, 8'd0);

    // Arm before the frame starts: one clean full frame.
    snap();
    doArm();
    applyStimulus(LINES, 1'b1, -1, -1);
    endFrame(1'b0);
    checkFrame("full", 1, 1, MAX_BYTES);
`ifdef CAM_CAPTURE_STATS_EN
    checkOutput("full_line_count", 32'(line_count), 32'(LINES));
    checkOutput("full_last_line_bytes", 32'(last_line_bytes), 32'(BYTES));
`endif

    // Arm during line 5: that frame is skipped, the next one is captured.
    snap();
    applyStimulus(LINES, 1'b0, 5, -1);
    checkOutput("midarm_no_writes", 32'(weCount - weSnap), 32'd0);
    applyStimulus(LINES, 1'b1, -1, -1);
    endFrame(1'b0);
    checkFrame("midarm", 1, 1, MAX_BYTES);

    // One line too many: writes stop at the limit and overflow is set.
    snap();
    doArm();
    applyStimulus(LINES + 1, 1'b1, -1, -1);
    endFrame(1'b0);
    checkFrame("overflow", 1, 1, MAX_BYTES);
    checkOutput("overflow_set", 32'(overflow), 32'd1);
`ifdef CAM_CAPTURE_STATS_EN
    checkOutput("overflow_line_count", 32'(line_count), 32'(LINES + 1));
`endif

    // Re-arm clears overflow; frame ends with href high on the vsync rise.
    snap();
    doArm();
    applyStimulus(LINES, 1'b1, -1, -1);
    endFrame(1'b1);
    checkFrame("href_on_rise", 1, 1, MAX_BYTES);

    // Reset at line 6 abandons the frame without frame_end.
    snap();
    doArm();
    applyStimulus(LINES, 1'b1, -1, 6);
    checkOutput("abort_frame_end_count", 32'(feCount - feSnap), 32'd0);
    checkOutput("abort_write_count", 32'(weCount - weSnap), 32'(6 * BYTES));
    checkOutput("abort_scoreboard_drained", 32'(sb.size()), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);

    // A fresh arm after the reset captures a complete frame.
    snap();
    doArm();
    applyStimulus(LINES, 1'b1, -1, -1);
    endFrame(1'b0);
    checkFrame("after_reset", 1, 1, MAX_BYTES);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
